// File: rtl/sum_window_acc_if.sv
//------------------------------------------------------------------------------
// sum_window_acc_if : valid/ready sample stream feeding sum_window_acc
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sum_window_acc_if;
  logic        in_valid;
  logic [10:0] in_data;
  logic        in_last;
  logic        in_ready;

  modport master (output in_valid, output in_data, output in_last, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface

`default_nettype wire

// File: rtl/sum_window_acc.sv
//------------------------------------------------------------------------------
// sum_window_acc : saturating sum over a window of up to LIMIT stream samples
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sum_window_acc #(
  parameter int LIMIT = 150,
  parameter int SUM_W = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  sum_window_acc_if.slave    s,
  output logic [SUM_W-1:0]   sum,
  output logic [10:0]        count,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [10:0]      c_last    = 11'(LIMIT - 1);
  localparam logic [SUM_W-1:0] c_sum_max = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SUM_W-1:0] r_sum;
  logic [10:0]      r_count;
  logic             r_ovf;
  logic             r_last_seen;
  logic             w_accept;
  logic             w_clear;
  logic [SUM_W:0]   w_sum_ext;
  logic             w_sat;

  assign w_accept  = (r_state == ST_RUN) && s.in_valid;
  assign w_clear   = start && (r_state != ST_RUN);
  // One extra bit catches the carry that signals saturation.
  assign w_sum_ext = {1'b0, r_sum} + (SUM_W + 1)'(s.in_data);
  assign w_sat     = w_sum_ext[SUM_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_RUN;
      ST_RUN: if (w_accept && (r_count == c_last || s.in_last)) w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_last_seen <= 1'b0;
    end else if (w_clear) begin
      r_sum       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_last_seen <= 1'b0;
    end else if (w_accept) begin
      r_count     <= r_count + 11'd1;
      r_sum       <= w_sat ? c_sum_max : w_sum_ext[SUM_W-1:0];
      r_ovf       <= r_ovf | w_sat;
      r_last_seen <= r_last_seen | s.in_last;
    end
  end

  assign s.in_ready = (r_state == ST_RUN);
  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);
  assign sum        = r_sum;
  assign count      = r_count;
  assign ovf        = r_ovf;

  a_count_le_limit: assert property (@(posedge clk) disable iff (rst) r_count <= 11'(LIMIT));
  a_done_nonzero:   assert property (@(posedge clk) disable iff (rst) done |-> r_count != 11'd0);
  a_done_full:      assert property (@(posedge clk) disable iff (rst)
                                     (done && !r_last_seen) |-> r_count == 11'(LIMIT));
  a_ovf_saturated:  assert property (@(posedge clk) disable iff (rst) r_ovf |-> r_sum == c_sum_max);

endmodule

`default_nettype wire

// File: tb/tb_sum_window_acc.sv
//------------------------------------------------------------------------------
// tb_sum_window_acc : directed checks on three configurations of sum_window_acc
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sum_window_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sum_window_acc_if if0 ();
  sum_window_acc_if if1 ();
  sum_window_acc_if if2 ();

  logic [21:0] sum0, sum2;
  logic [15:0] sum1;
  logic [10:0] count0, count1, count2;
  logic        busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;

  sum_window_acc #(.LIMIT(150), .SUM_W(22)) u0 (
    .clk(clk), .rst(rst), .start(start0), .s(if0.slave),
    .sum(sum0), .count(count0), .busy(busy0), .done(done0), .ovf(ovf0));
  sum_window_acc #(.LIMIT(150), .SUM_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .s(if1.slave),
    .sum(sum1), .count(count1), .busy(busy1), .done(done1), .ovf(ovf1));
  sum_window_acc #(.LIMIT(4), .SUM_W(22)) u2 (
    .clk(clk), .rst(rst), .start(start2), .s(if2.slave),
    .sum(sum2), .count(count2), .busy(busy2), .done(done2), .ovf(ovf2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if0.in_valid = 0; if0.in_data = '0; if0.in_last = 0;
    if1.in_valid = 0; if1.in_data = '0; if1.in_last = 0;
    if2.in_valid = 0; if2.in_data = '0; if2.in_last = 0;
    step(); step();
    rst = 0;
    step();

    // Reset state
    chk("rst_sum", 32'(sum0), 0);
    chk("rst_count", 32'(count0), 0);
    chk("rst_ready", 32'(if0.in_ready), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_ovf", 32'(ovf0), 0);

    // Samples offered in IDLE are ignored
    if0.in_valid = 1; if0.in_data = 11'd99;
    step();
    chk("idle_ignore", 32'(count0), 0);

    // Stream 1..150 back-to-back
    if0.in_valid = 0;
    start0 = 1; step(); start0 = 0;
    chk("t1_ready", 32'(if0.in_ready), 1);
    chk("t1_busy", 32'(busy0), 1);
    if0.in_valid = 1;
    for (int i = 1; i <= 150; i++) begin
      if0.in_data = 11'(i);
      step();
      if (i == 1)   chk("t1_first_count", 32'(count0), 1);
      if (i == 149) chk("t1_done_early", 32'(done0), 0);
    end
    chk("t1_done", 32'(done0), 1);
    chk("t1_ready_off", 32'(if0.in_ready), 0);
    chk("t1_sum", 32'(sum0), 11325);
    chk("t1_count", 32'(count0), 150);
    chk("t1_ovf", 32'(ovf0), 0);
    if0.in_data = 11'd151;
    step();
    chk("t1_no_extra_count", 32'(count0), 150);
    chk("t1_no_extra_sum", 32'(sum0), 11325);
    if0.in_valid = 0;

    // SUM_W=16 saturation
    start1 = 1; step(); start1 = 0;
    if1.in_valid = 1; if1.in_data = 11'd2047;
    for (int i = 1; i <= 150; i++) begin
      step();
      if (i == 32) begin
        chk("t2_sum32", 32'(sum1), 65504);
        chk("t2_ovf32", 32'(ovf1), 0);
      end
      if (i == 33) begin
        chk("t2_sum33", 32'(sum1), 65535);
        chk("t2_ovf33", 32'(ovf1), 1);
      end
    end
    if1.in_valid = 0;
    chk("t2_sum", 32'(sum1), 65535);
    chk("t2_ovf", 32'(ovf1), 1);
    chk("t2_count", 32'(count1), 150);
    chk("t2_done", 32'(done1), 1);

    // Restart from DONE, then 5,6,7 with gaps and in_last on 7
    start0 = 1; step(); start0 = 0;
    chk("t3_clr_sum", 32'(sum0), 0);
    chk("t3_clr_count", 32'(count0), 0);
    chk("t3_clr_done", 32'(done0), 0);
    chk("t3_ready", 32'(if0.in_ready), 1);
    step();
    chk("t3_gap0", 32'(count0), 0);
    if0.in_valid = 1; if0.in_data = 11'd5; step();
    if0.in_valid = 0; step(); step();
    chk("t3_gap1_sum", 32'(sum0), 5);
    chk("t3_gap1_count", 32'(count0), 1);
    if0.in_valid = 1; if0.in_data = 11'd6; step();
    if0.in_valid = 0; step();
    chk("t3_gap2_sum", 32'(sum0), 11);
    chk("t3_gap2_count", 32'(count0), 2);
    if0.in_valid = 1; if0.in_data = 11'd7; if0.in_last = 1; step();
    if0.in_last = 0;
    chk("t3_done", 32'(done0), 1);
    chk("t3_sum", 32'(sum0), 18);
    chk("t3_count", 32'(count0), 3);
    if0.in_data = 11'd9; step();
    chk("t3_hold", 32'(count0), 3);
    if0.in_valid = 0;

    // LIMIT=4 with in_last on the 4th sample
    start2 = 1; step(); start2 = 0;
    if2.in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      if2.in_data = 11'(i);
      if2.in_last = (i == 4);
      step();
    end
    if2.in_last = 0; if2.in_data = 11'd100;
    chk("t4_done", 32'(done2), 1);
    chk("t4_sum", 32'(sum2), 10);
    chk("t4_count", 32'(count2), 4);
    step(); step();
    chk("t4_stable_done", 32'(done2), 1);
    chk("t4_stable_busy", 32'(busy2), 0);
    chk("t4_stable_count", 32'(count2), 4);
    chk("t4_stable_sum", 32'(sum2), 10);
    if2.in_valid = 0;

    // Start during RUN is ignored
    start0 = 1; step(); start0 = 0;
    if0.in_valid = 1; if0.in_data = 11'd10; step();
    if0.in_valid = 0;
    start0 = 1; step(); start0 = 0;
    chk("t6_nostart_sum", 32'(sum0), 10);
    chk("t6_nostart_count", 32'(count0), 1);
    chk("t6_nostart_busy", 32'(busy0), 1);
    if0.in_valid = 1; if0.in_data = 11'd20; if0.in_last = 1; step();
    if0.in_valid = 0; if0.in_last = 0;
    chk("t6_sum", 32'(sum0), 30);
    chk("t6_count", 32'(count0), 2);
    chk("t6_done", 32'(done0), 1);

    // Asynchronous reset mid-RUN
    start0 = 1; step(); start0 = 0;
    if0.in_valid = 1; if0.in_data = 11'd3;
    for (int i = 0; i < 10; i++) step();
    if0.in_valid = 0;
    chk("t5_pre_count", 32'(count0), 10);
    chk("t5_pre_sum", 32'(sum0), 30);
    #2 rst = 1;
    #1;
    chk("t5_async_sum", 32'(sum0), 0);
    chk("t5_async_count", 32'(count0), 0);
    chk("t5_async_busy", 32'(busy0), 0);
    chk("t5_async_ready", 32'(if0.in_ready), 0);
    step();
    rst = 0;
    step();
    start0 = 1; step(); start0 = 0;
    chk("t5_fresh_count", 32'(count0), 0);
    if0.in_valid = 1; if0.in_data = 11'd7; if0.in_last = 1; step();
    if0.in_valid = 0; if0.in_last = 0;
    chk("t5_fresh_sum", 32'(sum0), 7);
    chk("t5_fresh_count1", 32'(count0), 1);
    chk("t5_fresh_done", 32'(done0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
